// File: rtl/output_sequencer.sv
// output_sequencer
//   Brings up the HDMI output path. It waits for both PLLs to be locked
//   continuously, releases the ADV7513 configurator, waits for it to report
//   ready and then for a frame buffer to become ready, and only then releases
//   ram2video. Losing lock, changing video mode or losing ADV7513 ready sends
//   the sequencer back to IDLE, and each such return is counted.
//
//   Optional feature: define WATCHDOG_EN to bound ADV_WAIT to READY_TIMEOUT
//   cycles. On timeout the block enters FAULT, sets the sticky error flag,
//   holds for STABLE_CYCLES cycles and then restarts.
//
// Parameters
//   STABLE_CYCLES  cycles both locks must be high before bring-up proceeds
//   READY_TIMEOUT  ADV_WAIT cycle limit (WATCHDOG_EN builds only)
// Ports
//   clock             in   HDMI pixel clock, the only clock of the block
//   reset             in   synchronous, active-high
//   pll54_locked      in   PLL lock flag, asynchronous
//   pll74_locked      in   PLL lock flag, asynchronous
//   adv7513_ready     in   ADV7513 configuration done, asynchronous
//   line_doubler      in   video mode from the 54 MHz domain, asynchronous
//   frame_start       in   single-cycle buffer-ready pulse, clock domain
//   adv7513_enable    out  releases the ADV7513 configurator
//   ram2video_enable  out  releases ram2video output generation
//   state             out  current state encoding
//   restart_count     out  saturating count of restarts
//   error             out  watchdog fault flag
module output_sequencer #(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned READY_TIMEOUT = 1048576
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll54_locked,
  input  logic       pll74_locked,
  input  logic       adv7513_ready,
  input  logic       line_doubler,
  input  logic       frame_start,
  output logic       adv7513_enable,
  output logic       ram2video_enable,
  output logic [2:0] state,
  output logic [7:0] restart_count,
  output logic       error
);

  localparam int unsigned CNT_MAX = (STABLE_CYCLES > READY_TIMEOUT) ? STABLE_CYCLES : READY_TIMEOUT;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
`ifdef WATCHDOG_EN
  localparam logic [CW-1:0] READY_LAST = CW'(READY_TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    ADV_START = 3'd2,
    ADV_WAIT  = 3'd3,
    SYNC_WAIT = 3'd4,
    RUN       = 3'd5,
    FAULT     = 3'd6
  } state_t;

  // Synchronizer bit order: {pll54, pll74, ready, line_doubler}
  logic [3:0] sync1, sync2;
  logic       ld_prev;
  logic       lk54, lk74, rdy, ld;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          rc_inc;
  logic          locks, ld_chg, restart;

  assign {lk54, lk74, rdy, ld} = sync2;
  assign locks  = lk54 & lk74;
  assign ld_chg = ld ^ ld_prev;
  assign state  = state_q;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    rc_inc  = 1'b0;
    restart = 1'b0;
    if (state_q inside {ADV_START, ADV_WAIT, SYNC_WAIT, RUN})
      restart = !locks || ld_chg || ((state_q inside {SYNC_WAIT, RUN}) && !rdy);

    case (state_q)
      IDLE: begin
        cnt_n   = '0;
        state_n = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // A mode change only restarts the stability window here.
        if (ld_chg || !locks) begin
          cnt_n = '0;
        end else if (cnt_q == STABLE_LAST) begin
          cnt_n   = '0;
          state_n = ADV_START;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      ADV_START: begin
        cnt_n   = '0;
        state_n = ADV_WAIT;
      end
      ADV_WAIT: begin
        if (rdy) begin
          cnt_n   = '0;
          state_n = SYNC_WAIT;
        end else begin
`ifdef WATCHDOG_EN
          if (cnt_q == READY_LAST) begin
            cnt_n   = '0;
            state_n = FAULT;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
`else
          cnt_n = '0;
`endif
        end
      end
      SYNC_WAIT: begin
        if (frame_start) state_n = RUN;
      end
      RUN: ;
      FAULT: begin
`ifdef WATCHDOG_EN
        if (cnt_q == STABLE_LAST) begin
          cnt_n   = '0;
          rc_inc  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
`else
        cnt_n   = '0;
        state_n = IDLE;
`endif
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase

    // Restart overrides any forward transition; multiple causes count once.
    if (restart) begin
      cnt_n   = '0;
      rc_inc  = 1'b1;
      state_n = IDLE;
    end
  end

  // Enables are registered from the next state so they track state exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1            <= '0;
      sync2            <= '0;
      ld_prev          <= 1'b0;
      state_q          <= IDLE;
      cnt_q            <= '0;
      restart_count    <= '0;
      adv7513_enable   <= 1'b0;
      ram2video_enable <= 1'b0;
    end else begin
      sync1            <= {pll54_locked, pll74_locked, adv7513_ready, line_doubler};
      sync2            <= sync1;
      ld_prev          <= ld;
      state_q          <= state_n;
      cnt_q            <= cnt_n;
      adv7513_enable   <= state_n inside {ADV_START, ADV_WAIT, SYNC_WAIT, RUN};
      ram2video_enable <= (state_n == RUN);
      if (rc_inc && restart_count != '1)
        restart_count <= restart_count + 8'd1;
    end
  end

`ifdef WATCHDOG_EN
  always_ff @(posedge clock) begin
    if (reset)
      error <= 1'b0;
    else if (state_n == FAULT)
      error <= 1'b1;
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_output_sequencer.sv
// tb_output_sequencer
//   Table of {inputs, cycles to apply, expected outputs}; each row pushes its
//   expectation to a scoreboard tagged with the cycle it is due, and a
//   negedge monitor compares when that cycle arrives. Hand-written sequences
//   cover restart-count saturation and reset while running.
//   Works with or without WATCHDOG_EN defined.
module tb_output_sequencer;

`ifdef WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, pll54_locked, pll74_locked, adv7513_ready, line_doubler, frame_start;
  logic       adv7513_enable, ram2video_enable, error;
  logic [2:0] state;
  logic [7:0] restart_count;

  output_sequencer #(.STABLE_CYCLES(16), .READY_TIMEOUT(64)) dut (
    .clock(clock), .reset(reset),
    .pll54_locked(pll54_locked), .pll74_locked(pll74_locked),
    .adv7513_ready(adv7513_ready), .line_doubler(line_doubler),
    .frame_start(frame_start),
    .adv7513_enable(adv7513_enable), .ram2video_enable(ram2video_enable),
    .state(state), .restart_count(restart_count), .error(error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string name;
    bit rst, p54, p74, rdy, ld, fs;
    int n;
    int st;
    bit adv, r2v;
    int rc;
    bit err;
  } vec_t;

  typedef struct {
    string name;
    int when;
    int st;
    bit adv, r2v;
    int rc;
    bit err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  // Scoreboard monitor: compares every expectation on the cycle it falls due.
  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].when <= cyc) begin
        checks++;
        if (sb[i].when < cyc || int'(state) != sb[i].st || adv7513_enable != sb[i].adv ||
            ram2video_enable != sb[i].r2v || int'(restart_count) != sb[i].rc || error != sb[i].err) begin
          failures++;
          $display("FAIL %s @%0d: got st=%0d adv=%0b r2v=%0b rc=%0d err=%0b, want st=%0d adv=%0b r2v=%0b rc=%0d err=%0b",
                   sb[i].name, cyc, state, adv7513_enable, ram2video_enable, restart_count, error,
                   sb[i].st, sb[i].adv, sb[i].r2v, sb[i].rc, sb[i].err);
        end
        sb.delete(i);
      end
    end
  end

  function automatic void add(string name, bit rst, bit p54, bit p74, bit rdy, bit ld, bit fs,
                              int n, int st, bit adv, bit r2v, int rc, bit err);
    vec_t v;
    v = '{name, rst, p54, p74, rdy, ld, fs, n, st, adv, r2v, rc, err};
    tbl.push_back(v);
  endfunction

  task automatic expect_at(string name, int n, int st, bit adv, bit r2v, int rc, bit err);
    exp_t e;
    e = '{name, cyc + n, st, adv, r2v, rc, err};
    sb.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_state(int s, int limit, string name);
    int k = 0;
    while (int'(state) != s && k < limit) begin
      step(1);
      k++;
    end
    if (int'(state) != s) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout, state=%0d want %0d", name, state, s);
    end
  endtask

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    int rc_model;

    //   name            rst p54 p74 rdy ld fs   n   st adv r2v rc err
    // After reset release: edge1 IDLE->WAIT_LOCK, edge2 locks visible
    // (count 0), count 15 at edge17, ADV_START at edge18.
    add("reset",          1, 1, 1, 0, 0, 0,   2,  0, 0, 0, 0, 0);
    add("wait_lock",      0, 1, 1, 0, 0, 0,  17,  1, 0, 0, 0, 0);
    add("adv_start",      0, 1, 1, 0, 0, 0,   1,  2, 1, 0, 0, 0);
    add("adv_wait",       0, 1, 1, 0, 0, 0,   1,  3, 1, 0, 0, 0);
    add("fs_ignored",     0, 1, 1, 0, 0, 1,   8,  3, 1, 0, 0, 0);
    add("ready_sync_lat", 0, 1, 1, 1, 0, 0,   2,  3, 1, 0, 0, 0);
    add("sync_wait",      0, 1, 1, 1, 0, 0,   1,  4, 1, 0, 0, 0);
    add("sync_hold",      0, 1, 1, 1, 0, 0,   5,  4, 1, 0, 0, 0);
    add("run",            0, 1, 1, 1, 0, 1,   1,  5, 1, 1, 0, 0);
    add("run_hold",       0, 1, 1, 1, 0, 0,  20,  5, 1, 1, 0, 0);
    add("mode_lat",       0, 1, 1, 1, 1, 0,   2,  5, 1, 1, 0, 0);
    add("mode_restart",   0, 1, 1, 1, 1, 0,   1,  0, 0, 0, 1, 0);
    add("rebring_wl",     0, 1, 1, 1, 1, 0,   1,  1, 0, 0, 1, 0);
    add("rebring_cnt",    0, 1, 1, 1, 1, 0,  15,  1, 0, 0, 1, 0);
    add("rebring_adv",    0, 1, 1, 1, 1, 0,   1,  2, 1, 0, 1, 0);
    add("rebring_wait",   0, 1, 1, 1, 1, 0,   1,  3, 1, 0, 1, 0);
    add("rebring_sync",   0, 1, 1, 1, 1, 0,   1,  4, 1, 0, 1, 0);
    add("rebring_run",    0, 1, 1, 1, 1, 1,   1,  5, 1, 1, 1, 0);
    add("rdy_lat",        0, 1, 1, 0, 1, 0,   2,  5, 1, 1, 1, 0);
    add("rdy_restart",    0, 1, 1, 0, 1, 0,   1,  0, 0, 0, 2, 0);
    add("glitch_wl",      0, 1, 1, 0, 1, 0,   1,  1, 0, 0, 2, 0);
    add("glitch_cnt10",   0, 1, 1, 0, 1, 0,  10,  1, 0, 0, 2, 0);
    add("glitch_low",     0, 1, 0, 0, 1, 0,   1,  1, 0, 0, 2, 0);
    // Low reaches the FSM on the 3rd edge (count cleared), ADV_START 16 later.
    add("glitch_delay",   0, 1, 1, 0, 1, 0,  17,  1, 0, 0, 2, 0);
    add("glitch_adv",     0, 1, 1, 0, 1, 0,   1,  2, 1, 0, 2, 0);
    add("wd_64_wait",     0, 1, 1, 0, 1, 0,  64,  3, 1, 0, 2, 0);
    add("wd_fault",       0, 1, 1, 0, 1, 0,   1, WD ? 6 : 3, !WD, 0, 2, WD);
    add("wd_fault_hold",  0, 1, 1, 0, 1, 0,  15, WD ? 6 : 3, !WD, 0, 2, WD);
    add("wd_fault_exit",  0, 1, 1, 0, 1, 0,   1, WD ? 0 : 3, !WD, 0, WD ? 3 : 2, WD);
    add("reset2",         1, 1, 1, 1, 1, 0,   1,  0, 0, 0, 0, 0);
    // line_doubler 0->1 after reset is seen in WAIT_LOCK: clears count, no restart.
    add("wl_mode_clear",  0, 1, 1, 1, 1, 0,  18,  1, 0, 0, 0, 0);
    add("wl_mode_adv",    0, 1, 1, 1, 1, 0,   1,  2, 1, 0, 0, 0);
    add("sim_sync",       0, 1, 1, 1, 1, 0,   2,  4, 1, 0, 0, 0);
    add("sim_run",        0, 1, 1, 1, 1, 1,   1,  5, 1, 1, 0, 0);
    add("sim_lat",        0, 0, 1, 1, 0, 0,   2,  5, 1, 1, 0, 0);
    add("sim_restart",    0, 0, 1, 1, 0, 0,   1,  0, 0, 0, 1, 0);

    foreach (tbl[i]) begin
      reset         = tbl[i].rst;
      pll54_locked  = tbl[i].p54;
      pll74_locked  = tbl[i].p74;
      adv7513_ready = tbl[i].rdy;
      line_doubler  = tbl[i].ld;
      frame_start   = tbl[i].fs;
      expect_at(tbl[i].name, tbl[i].n, tbl[i].st, tbl[i].adv, tbl[i].r2v, tbl[i].rc, tbl[i].err);
      step(tbl[i].n);
    end

    // Saturation: 300 more restarts via mode toggles in SYNC_WAIT.
    pll54_locked = 1'b1;
    rc_model = 1;
    for (int i = 0; i < 300; i++) begin
      wait_state(4, 200, "sat_reach_sync");
      line_doubler = ~line_doubler;
      wait_state(0, 10, "sat_restart");
      if (rc_model < 255) rc_model++;
      if (i == 0) chk("sat_first", int'(restart_count), rc_model);
    end
    chk("sat_255", int'(restart_count), 255);
    chk("sat_model", rc_model, 255);

    // Reset asserted while in RUN clears every output on the next edge.
    wait_state(4, 200, "rst_reach_sync");
    frame_start = 1'b1;
    expect_at("rst_pre_run", 1, 5, 1, 1, 255, 0);
    step(1);
    frame_start = 1'b0;
    reset = 1'b1;
    expect_at("rst_in_run", 1, 0, 0, 0, 0, 0);
    step(1);
    reset = 1'b0;
    step(3);

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
